// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with combinational lookup and a
// line-at-a-time refill engine fetching one word per accepted beat.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   addr                    fetch byte address (bits [1:0] ignored)
//   flush_i                 invalidate all lines; aborts an in-flight refill
//   rd_o                    fetched instruction (valid when instr_miss_f_o=0)
//   instr_miss_f_o          fetch in addr cannot be served this cycle
//   instr_cache_rep_en_o    one-cycle pulse on the cycle a line is installed
//   mem_req_o, mem_addr_o   backing-memory read request and word address
//   mem_rdata_i, mem_ready_i backing-memory read data and its valid strobe
module instr_cache #(
  parameter int unsigned NUM_SETS       = 32,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr,
  input  logic        flush_i,
  output logic [31:0] rd_o,
  output logic        instr_miss_f_o,
  output logic        instr_cache_rep_en_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int unsigned OFF_W    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W    = $clog2(NUM_SETS);
  localparam int unsigned LINE_LSB = OFF_W + 2;
  localparam int unsigned TAG_LSB  = LINE_LSB + IDX_W;
  localparam int unsigned TAG_W    = 32 - TAG_LSB;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        beat_q, beat_d;
  logic [31:0]             base_q, base_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [NUM_SETS-1:0]     valid_q;
  logic [TAG_W-1:0]        tag_q  [NUM_SETS];
  logic [31:0]             data_q [NUM_SETS][WORDS_PER_LINE];

  logic [OFF_W-1:0]        addr_off;
  logic [IDX_W-1:0]        addr_idx;
  logic [TAG_W-1:0]        addr_tag;
  logic                    hit;
  logic                    data_we;
  logic                    valid_clr;
  logic                    install;
  logic                    unused_addr;

  assign addr_off    = addr[LINE_LSB-1:2];
  assign addr_idx    = addr[TAG_LSB-1:LINE_LSB];
  assign addr_tag    = addr[31:TAG_LSB];
  assign unused_addr = ^addr[1:0];

  // Lookup only counts in IDLE; during REFILL the fetch is always stalled.
  assign hit            = (state_q == IDLE) && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign rd_o           = data_q[addr_idx][addr_off];
  assign instr_miss_f_o = !hit;

  // Next-state, refill sequencing and memory request.
  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    base_d               = base_q;
    idx_d                = idx_q;
    data_we              = 1'b0;
    valid_clr            = 1'b0;
    install              = 1'b0;
    mem_req_o            = 1'b0;
    mem_addr_o           = 32'h0;
    instr_cache_rep_en_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit && !flush_i) begin
          state_d = REFILL;
          base_d  = {addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
          idx_d   = addr_idx;
          beat_d  = '0;
        end
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + (32'(beat_q) << 2);
        if (flush_i) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (mem_ready_i) begin
          data_we   = 1'b1;
          // Drop the victim as soon as its data starts being overwritten.
          valid_clr = (beat_q == '0);
          if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            install = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + OFF_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons the line: no array writes and no install pulse.
    if (reset_i) begin
      data_we   = 1'b0;
      valid_clr = 1'b0;
      install   = 1'b0;
    end
    instr_cache_rep_en_o = install;
  end

  // FSM and refill context registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= 32'h0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  // Valid bits: reset and flush clear all; refill clears then sets the victim.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      valid_q <= '0;
    end else begin
      if (valid_clr) valid_q[idx_q] <= 1'b0;
      if (install)   valid_q[idx_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (data_we) data_q[idx_q][beat_q] <= mem_rdata_i;
    if (install) tag_q[idx_q] <= base_q[31:TAG_LSB];
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios followed by a
// randomized phase, all compared each cycle against a line-level cache model.
module tb_instr_cache;

  localparam int unsigned NS         = 32;
  localparam int unsigned WPL        = 4;
  localparam int unsigned LINE_BYTES = 4 * WPL;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        flush_i = 1'b0;
  logic [31:0] rd_o;
  logic        instr_miss_f_o;
  logic        instr_cache_rep_en_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] salt = 32'h0;

  instr_cache #(.NUM_SETS(NS), .WORDS_PER_LINE(WPL)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .addr                 (addr),
    .flush_i              (flush_i),
    .rd_o                 (rd_o),
    .instr_miss_f_o       (instr_miss_f_o),
    .instr_cache_rep_en_o (instr_cache_rep_en_o),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_rdata_i          (mem_rdata_i),
    .mem_ready_i          (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Backing memory: a fixed pseudo-random word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  assign mem_rdata_i = mem_word(mem_addr_o);

  function automatic int unsigned line_of(input logic [31:0] a);
    return a / LINE_BYTES;
  endfunction

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / LINE_BYTES) % NS;
  endfunction

  // Model: which line each set holds, plus the in-flight refill.
  bit          m_valid [NS];
  int unsigned m_line  [NS];
  bit          r_busy = 1'b0;
  int unsigned r_line = 0;
  int unsigned r_set  = 0;
  int unsigned r_cnt  = 0;

  logic [31:0] o_rd, o_maddr;
  logic        o_miss, o_req, o_rep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic invalidate_all();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic cyc(input logic [31:0] a, input logic fl, input logic rdy,
                     input logic rst, input bit chk_en);
    int unsigned s;
    bit          e_miss, e_req, e_rep;
    logic [31:0] e_maddr;
    @(negedge clk_i);
    addr = a; flush_i = fl; mem_ready_i = rdy; reset_i = rst;
    #1;
    o_miss = instr_miss_f_o; o_rd = rd_o; o_req = mem_req_o;
    o_maddr = mem_addr_o; o_rep = instr_cache_rep_en_o;
    s = set_of(a);
    if (!r_busy) begin
      e_miss  = !(m_valid[s] && m_line[s] == line_of(a));
      e_req   = 1'b0;
      e_maddr = 32'h0;
      e_rep   = 1'b0;
    end else begin
      e_miss  = 1'b1;
      e_req   = 1'b1;
      e_maddr = r_line * LINE_BYTES + 4 * r_cnt;
      e_rep   = rdy && !fl && !rst && (r_cnt == WPL - 1);
    end
    if (chk_en) begin
      chk("miss", 32'(o_miss), 32'(e_miss));
      chk("mem_req", 32'(o_req), 32'(e_req));
      chk("mem_addr", o_maddr, e_maddr);
      chk("rep_en", 32'(o_rep), 32'(e_rep));
      if (!e_miss) chk("rd", o_rd, mem_word({a[31:2], 2'b00}));
    end
    if (rst) begin
      r_busy = 1'b0;
      invalidate_all();
    end else if (r_busy) begin
      if (fl) begin
        r_busy = 1'b0;
        invalidate_all();
      end else if (rdy) begin
        if (r_cnt == 0) m_valid[r_set] = 1'b0;
        r_cnt++;
        if (r_cnt == WPL) begin
          m_valid[r_set] = 1'b1;
          m_line[r_set]  = r_line;
          r_busy         = 1'b0;
        end
      end
    end else if (fl) begin
      invalidate_all();
    end else if (e_miss) begin
      r_busy = 1'b1;
      r_line = line_of(a);
      r_set  = s;
      r_cnt  = 0;
    end
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] ra;
    salt = $urandom;
    invalidate_all();
    pool[0] = 32'h100; pool[1] = 32'h300; pool[2] = 32'h200; pool[3] = 32'h1140;

    cyc(32'h108, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(32'h108, 1'b0, 1'b1, 1'b1, 1'b1);

    // Cold miss on 0x108.
    cyc(32'h108, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cold_idle_miss", 32'(o_miss), 32'd1);
    chk("cold_idle_req", 32'(o_req), 32'd0);
    for (int b = 0; b < 4; b++) begin
      cyc(32'h108, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("cold_beat_addr", o_maddr, 32'h100 + 32'(4 * b));
      chk("cold_rep", 32'(o_rep), (b == 3) ? 32'd1 : 32'd0);
    end
    cyc(32'h108, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cold_hit", 32'(o_miss), 32'd0);
    chk("cold_rd", o_rd, mem_word(32'h108));

    // Hits on the rest of the line.
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hit_100", o_rd, mem_word(32'h100));
    cyc(32'h104, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hit_104", o_rd, mem_word(32'h104));
    cyc(32'h10C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hit_10c", o_rd, mem_word(32'h10C));
    chk("hit_req", 32'(o_req), 32'd0);

    // Conflict: 0x300 evicts 0x100 from set 16.
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("conf_beat_addr", o_maddr, 32'h300 + 32'(4 * b));
    end
    cyc(32'h304, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("conf_hit", 32'(o_miss), 32'd0);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("conf_remiss", 32'(o_miss), 32'd1);

    // Refill of 0x100 with a 3-cycle stall while addr moves to 0x200.
    cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("stall_addr_hold", o_maddr, 32'h108);
    end
    cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stall_rep", 32'(o_rep), 32'd1);
    cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stall_200_miss", 32'(o_miss), 32'd1);
    for (int b = 0; b < 4; b++) cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h10C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_100_hit", 32'(o_miss), 32'd0);

    // Flush at beat 2 of a refill of 0x300.
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_rep", 32'(o_rep), 32'd0);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_idle_req", 32'(o_req), 32'd0);
    chk("flush_100_miss", 32'(o_miss), 32'd1);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_refill_addr", o_maddr, 32'h100);
    for (int b = 0; b < 3; b++) cyc(32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) cyc(32'h200, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset at beat 1 of a refill of 0x300.
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(32'h300, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(32'h100, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_100_miss", 32'(o_miss), 32'd1);
    cyc(32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_200_miss", 32'(o_miss), 32'd1);

    // Randomized traffic over a few conflicting and disjoint lines.
    for (int n = 0; n < 600; n++) begin
      ra = pool[$urandom_range(3)] + 32'(4 * $urandom_range(3)) + 32'($urandom_range(3));
      cyc(ra, ($urandom_range(39) == 0), ($urandom_range(3) != 0),
          ($urandom_range(99) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 The block SHALL be configured by the following parameters (name, default, meaning):
- NUM_SETS, 32: number of direct-mapped lines; power of two, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, at least 2.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, input, 1: clock; all state updates on the rising edge.
- reset_i, input, 1: synchronous active-high reset.
- addr, input, 32: fetch byte address; bits [1:0] ignored.
- flush_i, input, 1: invalidate all lines.
- rd_o, output, 32: fetched instruction.
- instr_miss_f_o, output, 1: high while the fetch in addr cannot be served this cycle.
- instr_cache_rep_en_o, output, 1: one-cycle pulse when a line is installed.
- mem_req_o, output, 1: backing-memory read request.
- mem_addr_o, output, 32: word-aligned backing-memory read address.
- mem_rdata_i, input, 32: backing-memory read data.
- mem_ready_i, input, 1: mem_rdata_i is valid for mem_addr_o this cycle.

Function
REQ-004 Address split: offset = addr[log2(WORDS_PER_LINE)+1:2]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
REQ-005 Storage: per set one valid bit, one tag and WORDS_PER_LINE data words; data/tag arrays need no reset, valid bits do.
REQ-006 Lookup SHALL be combinational: hit = valid[index] AND stored tag == addr tag, evaluated only in IDLE.
REQ-007 rd_o SHALL equal data[index][offset] on a hit; on a miss rd_o is don't-care, and the verifier checks it only when instr_miss_f_o=0.
REQ-008 instr_miss_f_o SHALL be high when (IDLE and not hit) or state=REFILL.
REQ-009 The FSM SHALL have two states, IDLE and REFILL.
REQ-010 IDLE to REFILL: on a miss with flush_i=0, latch line_base = {addr[31:offset_msb+1], zeros} and the index, and clear beat counter to 0.
REQ-011 In REFILL, mem_req_o SHALL be 1 and mem_addr_o SHALL be line_base + 4*beat; mem_req_o=0 and mem_addr_o=0 in IDLE.
REQ-012 In REFILL, when mem_ready_i=1, mem_rdata_i SHALL be written to data[latched index][beat] and beat SHALL increment; mem_ready_i=0 holds beat and stalls indefinitely.
REQ-013 On the beat with beat=WORDS_PER_LINE-1 and mem_ready_i=1, the block SHALL write the tag, set valid, pulse instr_cache_rep_en_o for that cycle, and return to IDLE.
REQ-014 The cycle after install, a fetch of the same line SHALL hit with 0 extra cycles; hit latency is 0 cycles and miss penalty is 1 + WORDS_PER_LINE × (memory wait) cycles.
REQ-015 addr changes during REFILL SHALL be ignored; the latched line completes, then lookup uses the current addr.
REQ-016 Before install, the victim line's valid bit SHALL be cleared on the first beat write, so a partially refilled line never hits.
REQ-017 flush_i=1 SHALL clear all valid bits at the next edge.
REQ-018 flush_i=1 in REFILL SHALL abort the refill: return to IDLE, no install, no rep_en pulse, and the mem_ready_i beat that cycle is discarded.
REQ-019 flush_i=1 in IDLE on a miss SHALL suppress the transition to REFILL for that cycle.

Reset
REQ-020 reset_i=1 SHALL force state IDLE, beat=0, all valid bits 0, mem_req_o=0, and instr_cache_rep_en_o=0 at the next edge.
REQ-021 reset_i SHALL take priority over flush_i and mem_ready_i, including mid-REFILL, which abandons the line with no install.
REQ-022 After reset, every lookup SHALL miss until its line is installed.

Verification
REQ-023 The bench SHALL cover these directed scenarios (defaults NUM_SETS=32, WORDS_PER_LINE=4; stimulus -> required response):
- Cold miss: addr=0x108 after reset, mem_ready_i=1 each cycle -> mem_addr_o 0x100,0x104,0x108,0x10C on consecutive cycles, rep_en pulse on 4th beat, next cycle miss=0 and rd_o=word returned for 0x108.
- Hits: after the above, addr=0x100,0x104,0x10C -> miss=0 each cycle, rd_o matches backing words, mem_req_o=0.
- Conflict: addr=0x300 (same index 16, new tag) -> refill 0x300..0x30C; then addr=0x100 misses again.
- Stall and addr change: mem_ready_i low 3 cycles mid-refill while addr switches to 0x200 -> mem_addr_o holds, line 0x100 installed, then 0x200 misses.
- Flush mid-refill: flush_i=1 at beat 2 -> state IDLE, no rep_en pulse, addr=0x100 misses and refills from 0x100.
- Reset mid-refill: reset_i=1 at beat 1 -> mem_req_o=0 next cycle, all previously installed lines miss.
